// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word fetches to instruction memory,
// buffers returned words in a small prefetch FIFO and hands {pc, instr} to decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    output logic [1:0]  imem_size,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        fault
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   CNT_ZERO  = (AW+1)'(0);
    localparam logic [AW-1:0] PTR_ZERO  = AW'(0);
    localparam logic [AW+1:0] DEPTH_W   = (AW+2)'(DEPTH);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t        state_r;
    logic [31:0]   fetch_pc_r;
    logic          inflight_r;
    logic [31:0]   inflight_pc_r;
    logic [AW:0]   count_r;
    logic [AW-1:0] head_r;
    logic [AW-1:0] tail_r;
    logic          fault_r;
    logic [31:0]   pc_mem_r    [DEPTH];
    logic [31:0]   instr_mem_r [DEPTH];

    logic          run_s;
    logic          pop_s;
    logic          push_s;
    logic          issue_s;
    logic          misalign_s;
    logic [AW+1:0] occupancy_s;

    assign imem_addr = fetch_pc_r;
    assign imem_size = 2'd3;
    assign out_valid = (count_r != CNT_ZERO);
    assign out_pc    = pc_mem_r[head_r];
    assign out_instr = instr_mem_r[head_r];
    assign fault     = fault_r;

    // Handshake, issue-credit and capture decisions for the current cycle.
    always_comb begin
        run_s       = (state_r == ST_RUN);
        pop_s       = out_valid && out_ready;
        misalign_s  = (redirect_pc[1:0] != 2'b00);
        push_s      = run_s && inflight_r && !redirect_valid;
        // Credit counts words already buffered plus the one still returning from memory.
        occupancy_s = {1'b0, count_r} + {{(AW+1){1'b0}}, inflight_r}
                    - {{(AW+1){1'b0}}, pop_s};
        if (run_s && !redirect_valid && (occupancy_s < DEPTH_W)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // PC, in-flight tracking, prefetch FIFO and run/halt state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_RUN;
            fetch_pc_r    <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= 32'h0000_0000;
            count_r       <= CNT_ZERO;
            head_r        <= PTR_ZERO;
            tail_r        <= PTR_ZERO;
            fault_r       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i]    <= 32'h0000_0000;
                instr_mem_r[i] <= 32'h0000_0000;
            end
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (redirect_valid) begin
                        // Flush everything; a capture due at this edge is dropped.
                        count_r    <= CNT_ZERO;
                        head_r     <= PTR_ZERO;
                        tail_r     <= PTR_ZERO;
                        inflight_r <= 1'b0;
                        if (misalign_s) begin
                            state_r <= ST_HALT;
                            fault_r <= 1'b1;
                        end else begin
                            fetch_pc_r <= redirect_pc;
                        end
                    end else begin
                        if (push_s) begin
                            pc_mem_r[tail_r]    <= inflight_pc_r;
                            instr_mem_r[tail_r] <= imem_rdata;
                            tail_r              <= tail_r + PTR_ONE;
                        end
                        if (pop_s) begin
                            head_r <= head_r + PTR_ONE;
                        end
                        case ({push_s, pop_s})
                            2'b10:   count_r <= count_r + CNT_ONE;
                            2'b01:   count_r <= count_r - CNT_ONE;
                            default: count_r <= count_r;
                        endcase
                        if (issue_s) begin
                            fetch_pc_r    <= fetch_pc_r + 32'd4;
                            inflight_r    <= 1'b1;
                            inflight_pc_r <= fetch_pc_r;
                        end else begin
                            inflight_r <= 1'b0;
                        end
                    end
                end
                ST_HALT: begin
                    state_r    <= ST_HALT;
                    fault_r    <= 1'b1;
                    inflight_r <= 1'b0;
                    count_r    <= CNT_ZERO;
                end
                default: begin
                    state_r    <= ST_HALT;
                    fault_r    <= 1'b1;
                    inflight_r <= 1'b0;
                    count_r    <= CNT_ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit against a queue-based reference model, plus a
// second instance reset near the top of the address space to show PC wrap.
module tb_fetch_unit;

    localparam int          DEPTH   = 2;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic        clock;
    logic        reset_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [1:0]  imem_size;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        fault;

    logic [31:0] w_addr;
    logic [1:0]  w_size;
    logic [31:0] w_rdata;
    logic        w_valid;
    logic [31:0] w_pc;
    logic [31:0] w_instr;
    logic        w_fault;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] m_fetch_pc;
    bit          m_halt;
    logic [63:0] m_fifo[$];
    logic [31:0] m_pend[$];
    logic [31:0] w_exp;
    int          w_seen;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_size(imem_size), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .fault(fault)
    );

    fetch_unit #(.RESET_PC(WRAP_PC), .DEPTH(DEPTH)) dut_wrap (
        .clock(clock), .reset_n(reset_n),
        .redirect_valid(1'b0), .redirect_pc(32'h0000_0000),
        .imem_addr(w_addr), .imem_size(w_size), .imem_rdata(w_rdata),
        .out_valid(w_valid), .out_ready(1'b1),
        .out_pc(w_pc), .out_instr(w_instr), .fault(w_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_word = 32'h1111_1111;
            32'h0000_0004: mem_word = 32'h2222_2222;
            32'h0000_0008: mem_word = 32'h3333_3333;
            default:       mem_word = {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    // Synchronous instruction memories: word for the address presented this cycle
    always @(posedge clock) begin
        imem_rdata <= mem_word(imem_addr);
        w_rdata    <= mem_word(w_addr);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fetch_pc = 32'h0000_0000;
        m_halt     = 1'b0;
        m_fifo.delete();
        m_pend.delete();
        w_exp      = WRAP_PC;
    endtask

    // One clock edge of the fetch rules: redirect wins, else capture, pop, issue on credit.
    task automatic model_update();
        bit pop;
        int occ;
        pop = (m_fifo.size() != 0) && out_ready;
        if (!m_halt) begin
            if (redirect_valid) begin
                m_fifo.delete();
                m_pend.delete();
                if (redirect_pc[1:0] != 2'b00) m_halt = 1'b1;
                else m_fetch_pc = redirect_pc;
            end else begin
                occ = m_fifo.size() + m_pend.size() - (pop ? 1 : 0);
                if (pop) void'(m_fifo.pop_front());
                if (m_pend.size() != 0) m_fifo.push_back({m_pend[0], mem_word(m_pend[0])});
                m_pend.delete();
                if (occ < DEPTH) begin
                    m_pend.push_back(m_fetch_pc);
                    m_fetch_pc = m_fetch_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic [63:0] head;
        check_eq("out_valid", out_valid, (m_fifo.size() != 0));
        if (m_fifo.size() != 0) begin
            head = m_fifo[0];
            check_eq("out_pc", out_pc, head[63:32]);
            check_eq("out_instr", out_instr, head[31:0]);
        end
        check_eq("imem_addr", imem_addr, m_fetch_pc);
        check_eq("fault", fault, m_halt);
        if (w_valid) begin
            check_eq("wrap_pc", w_pc, w_exp);
            check_eq("wrap_instr", w_instr, mem_word(w_exp));
            w_exp = w_exp + 32'd4;
            w_seen++;
        end
    endtask

    // Inputs are set at a negedge; advance one edge and check at the next negedge.
    task automatic step();
        @(posedge clock);
        model_update();
        @(negedge clock);
        check_outputs();
    endtask

    // Asynchronous reset asserted between edges, checked before any clock edge.
    task automatic reset_mid();
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("rst_valid", out_valid, 1'b0);
        check_eq("rst_fault", fault, 1'b0);
        check_eq("rst_addr", imem_addr, 32'h0000_0000);
        check_eq("rst_wrap_addr", w_addr, WRAP_PC);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [31:0] frozen;
        int          found;
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0000_0000;
        out_ready      = 1'b1;
        model_reset();
        w_seen = 0;
        repeat (2) @(negedge clock);
        check_eq("reset_valid", out_valid, 1'b0);
        check_eq("reset_pc", out_pc, 32'h0000_0000);
        check_eq("reset_instr", out_instr, 32'h0000_0000);
        check_eq("reset_fault", fault, 1'b0);
        check_eq("reset_addr", imem_addr, 32'h0000_0000);
        check_eq("imem_size", imem_size, 2'd3);
        check_eq("wrap_size", w_size, 2'd3);
        reset_n = 1'b1;

        // Streaming with decode always ready
        repeat (8) step();

        // Decode stalled from reset: FIFO fills, fetch address stalls
        reset_mid();
        out_ready = 1'b0;
        repeat (5) step();
        check_eq("stall_addr", imem_addr, 32'h0000_0008);
        out_ready = 1'b1;
        repeat (6) step();

        // Redirect while pc 0x8 is in flight
        reset_mid();
        repeat (3) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        step();
        check_eq("redir_flush", out_valid, 1'b0);
        redirect_valid = 1'b0;
        found = 0;
        for (int i = 0; i < 6 && found == 0; i++) begin
            step();
            if (out_valid) begin
                check_eq("redir_first_pc", out_pc, 32'h0000_0040);
                found = 1;
            end
        end
        check_eq("redir_timeout", found, 1);
        repeat (4) step();

        // Misaligned redirect halts until reset
        frozen         = imem_addr;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0042;
        step();
        check_eq("halt_fault", fault, 1'b1);
        redirect_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            out_ready      = 1'($urandom_range(0, 1));
            redirect_valid = 1'($urandom_range(0, 1));
            redirect_pc    = $urandom_range(0, 255) & 32'hFFFF_FFFC;
            step();
            check_eq("halt_addr", imem_addr, frozen);
            check_eq("halt_valid", out_valid, 1'b0);
        end
        redirect_valid = 1'b0;
        reset_mid();

        // Random traffic with aligned redirects
        for (int i = 0; i < 400; i++) begin
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc    = $urandom_range(0, 1023) & 32'hFFFF_FFFC;
            step();
            if (i == 200) begin
                redirect_valid = 1'b0;
                reset_mid();
            end
        end
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        repeat (4) step();
        check_eq("wrap_seen", (w_seen >= 3), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
